// File: rtl/fft_r2_iter.sv
// Iterative radix-2 DIT FFT/IFFT: streams a frame in (bit-reversed into a register bank),
// runs one in-place butterfly per clock, then streams the natural-order spectrum out.
module fft_r2_iter #(
    parameter int LOG2N  = 3,
    parameter int DATA_W = 16,
    parameter int TW_W   = 16,
    parameter int SCALE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic                     in_inverse,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]         out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     ovf
);
    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int PW   = DATA_W + TW_W + 1;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_UNLOAD = 2'd2;

    localparam logic signed [PW-1:0] RND  = PW'(1) <<< (TW_W - 2);
    localparam logic signed [PW-1:0] MAXV = (PW'(1) <<< (DATA_W - 1)) - PW'(1);
    localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);
    localparam real TW_MAX = 2.0 ** (TW_W - 1) - 1.0;

    logic [1:0]              state;
    logic [LOG2N-1:0]        in_cnt;
    logic [LOG2N-1:0]        stage;
    logic [LOG2N-2:0]        bfly;
    logic                    inverse;
    logic signed [DATA_W-1:0] bank_re [N];
    logic signed [DATA_W-1:0] bank_im [N];
    logic signed [TW_W-1:0]  rom_re [HALF];
    logic signed [TW_W-1:0]  rom_im [HALF];

    // Twiddle ROM W_k = cos(2*pi*k/N) - j*sin(2*pi*k/N), rounded to nearest at elaboration
    for (genvar t = 0; t < HALF; t++) begin : g_tw
        localparam real ANG = 6.283185307179586 * t / N;
        localparam real C   = $cos(ANG) * TW_MAX;
        localparam real S   = $sin(ANG) * TW_MAX;
        localparam int  CQ  = (C >= 0.0) ? $rtoi(C + 0.5) : -$rtoi(0.5 - C);
        localparam int  SQ  = (S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(0.5 - S);
        assign rom_re[t] = TW_W'(CQ);
        assign rom_im[t] = TW_W'(-SQ);
    end

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = x[LOG2N-1-i];
        end
        return r;
    endfunction

    // Returns {saturation flag, DATA_W result}; scaling mode halves and never flags
    function automatic logic [DATA_W:0] post(input logic signed [PW-1:0] x);
        logic [DATA_W:0] r;
        if (SCALE != 0) begin
            r = {1'b0, DATA_W'(x >>> 1)};
        end else if (x > MAXV) begin
            r = {1'b1, DATA_W'(MAXV)};
        end else if (x < MINV) begin
            r = {1'b1, DATA_W'(MINV)};
        end else begin
            r = {1'b0, DATA_W'(x)};
        end
        return r;
    endfunction

    logic [LOG2N-1:0]        m, lo_mask, idx_a, idx_b, tw_full, next_index;
    logic [LOG2N-2:0]        tw_idx;
    logic signed [TW_W-1:0]  w_re, w_im;
    logic signed [PW-1:0]    pr_full, pi_full, p_re, p_im;
    logic signed [PW-1:0]    sa_re, sa_im, sb_re, sb_im;
    logic [DATA_W:0]         ra_re, ra_im, rb_re, rb_im;
    logic                    ovf_hit;

    // Butterfly datapath for the current (stage, bfly) pair: i = g*2h + j, partner i + h
    always_comb begin
        m          = LOG2N'(bfly);
        lo_mask    = (LOG2N'(1) << stage) - LOG2N'(1);
        idx_a      = ((m & ~lo_mask) << 1) | (m & lo_mask);
        idx_b      = idx_a | (LOG2N'(1) << stage);
        tw_full    = (m & lo_mask) << (LOG2N'(LOG2N - 1) - stage);
        tw_idx     = (LOG2N-1)'(tw_full);
        next_index = out_index + LOG2N'(1);
        w_re       = rom_re[tw_idx];
        w_im       = inverse ? -rom_im[tw_idx] : rom_im[tw_idx];
        pr_full    = PW'(bank_re[idx_b]) * PW'(w_re) - PW'(bank_im[idx_b]) * PW'(w_im) + RND;
        pi_full    = PW'(bank_re[idx_b]) * PW'(w_im) + PW'(bank_im[idx_b]) * PW'(w_re) + RND;
        p_re       = pr_full >>> (TW_W - 1);
        p_im       = pi_full >>> (TW_W - 1);
        sa_re      = PW'(bank_re[idx_a]) + p_re;
        sa_im      = PW'(bank_im[idx_a]) + p_im;
        sb_re      = PW'(bank_re[idx_a]) - p_re;
        sb_im      = PW'(bank_im[idx_a]) - p_im;
        ra_re      = post(sa_re);
        ra_im      = post(sa_im);
        rb_re      = post(sb_re);
        rb_im      = post(sb_im);
        ovf_hit    = ra_re[DATA_W] | ra_im[DATA_W] | rb_re[DATA_W] | rb_im[DATA_W];
    end

    // Sample bank: bit-reversed loading, then in-place butterfly write-back
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && in_valid && in_ready) begin
            bank_re[bitrev(in_cnt)] <= in_re;
            bank_im[bitrev(in_cnt)] <= in_im;
        end else if (state == ST_CALC) begin
            bank_re[idx_a] <= ra_re[DATA_W-1:0];
            bank_im[idx_a] <= ra_im[DATA_W-1:0];
            bank_re[idx_b] <= rb_re[DATA_W-1:0];
            bank_im[idx_b] <= rb_im[DATA_W-1:0];
        end
    end

    // Frame sequencing and registered handshake/output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_LOAD;
            in_cnt    <= '0;
            stage     <= '0;
            bfly      <= '0;
            inverse   <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        in_cnt <= in_cnt + LOG2N'(1);
                        if (in_cnt == '0) begin
                            inverse <= in_inverse;
                            ovf     <= 1'b0;
                        end
                        if (in_cnt == LOG2N'(N - 1)) begin
                            state    <= ST_CALC;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    ovf  <= ovf | ovf_hit;
                    bfly <= bfly + (LOG2N-1)'(1);
                    if (bfly == (LOG2N-1)'(HALF - 1)) begin
                        if (stage == LOG2N'(LOG2N - 1)) begin
                            stage <= '0;
                            state <= ST_UNLOAD;
                        end else begin
                            stage <= stage + LOG2N'(1);
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_re    <= bank_re[0];
                        out_im    <= bank_im[0];
                        out_index <= '0;
                        out_last  <= 1'b0;
                    end else if (out_ready) begin
                        if (out_last) begin
                            state     <= ST_LOAD;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            out_re    <= bank_re[next_index];
                            out_im    <= bank_im[next_index];
                            out_index <= next_index;
                            out_last  <= (next_index == LOG2N'(N - 1));
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_r2_iter.sv
// Directed bench for fft_r2_iter at N=8: a scaled instance for FFT/IFFT/handshake/reset
// cases and an unscaled instance for saturation and ovf behaviour.
module tb_fft_r2_iter;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              sel0;
    logic              in_valid, in_inverse, out_ready;
    logic signed [15:0] in_re, in_im;

    logic              u1_in_ready, u1_out_valid, u1_out_last, u1_busy, u1_ovf;
    logic signed [15:0] u1_out_re, u1_out_im;
    logic [2:0]        u1_out_index;
    logic              u0_in_ready, u0_out_valid, u0_out_last, u0_busy, u0_ovf;
    logic signed [15:0] u0_out_re, u0_out_im;
    logic [2:0]        u0_out_index;

    fft_r2_iter #(.LOG2N(3), .DATA_W(16), .TW_W(16), .SCALE(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid & ~sel0), .in_ready(u1_in_ready),
        .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse),
        .out_valid(u1_out_valid), .out_ready(out_ready & ~sel0),
        .out_re(u1_out_re), .out_im(u1_out_im), .out_index(u1_out_index),
        .out_last(u1_out_last), .busy(u1_busy), .ovf(u1_ovf)
    );

    fft_r2_iter #(.LOG2N(3), .DATA_W(16), .TW_W(16), .SCALE(0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid & sel0), .in_ready(u0_in_ready),
        .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse),
        .out_valid(u0_out_valid), .out_ready(out_ready & sel0),
        .out_re(u0_out_re), .out_im(u0_out_im), .out_index(u0_out_index),
        .out_last(u0_out_last), .busy(u0_busy), .ovf(u0_ovf)
    );

    wire              o_ready = sel0 ? u0_in_ready  : u1_in_ready;
    wire              o_valid = sel0 ? u0_out_valid : u1_out_valid;
    wire              o_last  = sel0 ? u0_out_last  : u1_out_last;
    wire              o_busy  = sel0 ? u0_busy      : u1_busy;
    wire              o_ovf   = sel0 ? u0_ovf       : u1_ovf;
    wire signed [15:0] o_re   = sel0 ? u0_out_re    : u1_out_re;
    wire signed [15:0] o_im   = sel0 ? u0_out_im    : u1_out_im;
    wire [2:0]        o_index = sel0 ? u0_out_index : u1_out_index;

    int errors = 0;
    int checks = 0;
    int fr_re [N];
    int fr_im [N];
    int got_re [N];
    int got_im [N];
    logic got_ovf;
    logic [3:0] pat = 4'b1001;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert (obs >= exp - tol && obs <= exp + tol) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d(+-%0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic set_frame(input int k, input int v);
        for (int i = 0; i < N; i++) begin
            fr_re[i] = (k < 0 || i == k) ? v : 0;
            fr_im[i] = 0;
        end
    endtask

    task automatic send_frame(input logic inv);
        chk("in_ready_before_frame", o_ready, 1);
        for (int n = 0; n < N; n++) begin
            in_re      = 16'(fr_re[n]);
            in_im      = 16'(fr_im[n]);
            in_inverse = inv;
            in_valid   = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_frame(input logic toggle, input string tag);
        int got = 0;
        int cyc = 0;
        logic held = 1'b0;
        logic signed [15:0] h_re = 16'sd0;
        logic [2:0] h_idx = 3'd0;
        while (got < N && cyc < 200) begin
            out_ready = toggle ? pat[cyc % 4] : 1'b1;
            if (held) begin
                chk($sformatf("%s_hold_re", tag), o_re, h_re);
                chk($sformatf("%s_hold_idx", tag), o_index, h_idx);
                held = 1'b0;
            end
            if (o_valid) begin
                if (out_ready) begin
                    chk($sformatf("%s_index%0d", tag, got), o_index, got);
                    chk($sformatf("%s_last%0d", tag, got), o_last, (got == N - 1) ? 1 : 0);
                    got_re[got] = o_re;
                    got_im[got] = o_im;
                    if (got == 0) got_ovf = o_ovf;
                    got++;
                end else begin
                    held  = 1'b1;
                    h_re  = o_re;
                    h_idx = o_index;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk($sformatf("%s_count", tag), got, N);
        chk($sformatf("%s_in_ready_after", tag), o_ready, 1);
        chk($sformatf("%s_out_valid_after", tag), o_valid, 0);
    endtask

    initial begin
        int lat;
        int seen;
        sel0 = 1'b0; reset = 1'b1; in_valid = 1'b0; in_inverse = 1'b0;
        out_ready = 1'b0; in_re = 16'sd0; in_im = 16'sd0; got_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", o_ready, 1);
        chk("rst_out_valid", o_valid, 0);
        chk("rst_out_re", o_re, 0);
        chk("rst_out_index", o_index, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ovf", o_ovf, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Impulse FFT; junk in_valid during CALC must be ignored
        set_frame(0, 1000);
        send_frame(1'b0);
        chk("t1_busy", o_busy, 1);
        chk("t1_in_ready_calc", o_ready, 0);
        in_valid = 1'b1; in_re = 16'sd5555;
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("t1_latency", lat, 13);
        recv_frame(1'b0, "t1");
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t1_re%0d", k), got_re[k], 125);
            chk($sformatf("t1_im%0d", k), got_im[k], 0);
        end
        chk("t1_busy_idle", o_busy, 0);

        // IFFT of DC bin
        set_frame(0, 8000);
        send_frame(1'b1);
        recv_frame(1'b0, "t2");
        for (int k = 0; k < N; k++) begin
            chk_tol($sformatf("t2_re%0d", k), got_re[k], 1000, 1);
            chk_tol($sformatf("t2_im%0d", k), got_im[k], 0, 1);
        end

        // IFFT of bin 1: a rotating phasor
        set_frame(1, 8000);
        send_frame(1'b1);
        recv_frame(1'b0, "t3");
        chk_tol("t3_re0", got_re[0], 1000, 2);
        chk_tol("t3_im0", got_im[0], 0, 2);
        chk_tol("t3_re1", got_re[1], 707, 2);
        chk_tol("t3_im1", got_im[1], 707, 2);
        chk_tol("t3_re2", got_re[2], 0, 2);
        chk_tol("t3_im2", got_im[2], 1000, 2);
        chk_tol("t3_re4", got_re[4], -1000, 2);
        chk_tol("t3_im4", got_im[4], 0, 2);
        chk_tol("t3_re6", got_re[6], 0, 2);
        chk_tol("t3_im6", got_im[6], -1000, 2);

        // Backpressure 1-0-0-1 during UNLOAD
        set_frame(0, 1000);
        send_frame(1'b0);
        recv_frame(1'b1, "t5");
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t5_re%0d", k), got_re[k], 125);
        end

        // Unscaled instance: saturation and sticky ovf
        sel0 = 1'b1;
        set_frame(-1, 32767);
        send_frame(1'b0);
        recv_frame(1'b0, "t4");
        chk("t4_re0_sat", got_re[0], 32767);
        chk("t4_im0", got_im[0], 0);
        chk("t4_ovf", got_ovf, 1);
        chk("t4_ovf_hold", o_ovf, 1);
        set_frame(-1, 0);
        send_frame(1'b0);
        recv_frame(1'b0, "t4z");
        chk("t4z_re0", got_re[0], 0);
        chk("t4z_ovf", got_ovf, 0);
        chk("t4z_ovf_after", o_ovf, 0);

        // Reset in the middle of CALC
        sel0 = 1'b0;
        set_frame(0, 1000);
        send_frame(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_in_calc", o_busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_in_ready", o_ready, 1);
        chk("t6_out_valid", o_valid, 0);
        chk("t6_busy", o_busy, 0);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        chk("t6_no_partial_output", seen, 0);
        send_frame(1'b0);
        recv_frame(1'b0, "t6");
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t6_re%0d", k), got_re[k], 125);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
